// File: rtl/ex_operand_stage_if.sv
// Bundle of decode-side, forwarding and ALU-side signals of the ID/EX operand stage.
interface ex_operand_stage_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_rd1;
   logic [DATA_W-1:0]     in_rd2;
   logic [DATA_W-1:0]     in_imm;
   logic [REG_ADDR_W-1:0] in_rs1;
   logic [REG_ADDR_W-1:0] in_rs2;
   logic [REG_ADDR_W-1:0] in_rd;
   logic                  in_alu_src;
   logic [2:0]            in_alu_control;
   logic                  in_reg_write;
   logic                  fwd_mem_en;
   logic [REG_ADDR_W-1:0] fwd_mem_rd;
   logic [DATA_W-1:0]     fwd_mem_data;
   logic                  fwd_wb_en;
   logic [REG_ADDR_W-1:0] fwd_wb_rd;
   logic [DATA_W-1:0]     fwd_wb_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     alu_a;
   logic [DATA_W-1:0]     alu_b;
   logic [2:0]            alu_control;
   logic [REG_ADDR_W-1:0] out_rd;
   logic                  out_reg_write;
   logic [DATA_W-1:0]     out_store_data;

   // Pipeline environment side: decode, MEM/WB forwarding sources, EX/MEM consumer.
   modport master (
      output flush, in_valid, in_rd1, in_rd2, in_imm, in_rs1, in_rs2, in_rd,
             in_alu_src, in_alu_control, in_reg_write,
             fwd_mem_en, fwd_mem_rd, fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data,
             out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_control, out_rd,
             out_reg_write, out_store_data
   );

   // Operand stage side.
   modport slave (
      input  flush, in_valid, in_rd1, in_rd2, in_imm, in_rs1, in_rs2, in_rd,
             in_alu_src, in_alu_control, in_reg_write,
             fwd_mem_en, fwd_mem_rd, fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data,
             out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_control, out_rd,
             out_reg_write, out_store_data
   );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU.
module ex_operand_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input logic               clk,
   input logic               rst,
   ex_operand_stage_if.slave io
);

   logic                  valid_q;
   logic [DATA_W-1:0]     rd1_q;
   logic [DATA_W-1:0]     rd2_q;
   logic [DATA_W-1:0]     imm_q;
   logic [REG_ADDR_W-1:0] rs1_q;
   logic [REG_ADDR_W-1:0] rs2_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  alu_src_q;
   logic [2:0]            alu_control_q;
   logic                  reg_write_q;

   logic                  accept;
   logic [DATA_W-1:0]     op_a;
   logic [DATA_W-1:0]     op_b;

   assign io.in_ready = !valid_q || io.out_ready;
   assign accept      = io.in_valid && io.in_ready;

   // Pipeline register: flush beats load, load beats drain, otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q       <= 1'b0;
         rd1_q         <= '0;
         rd2_q         <= '0;
         imm_q         <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         alu_src_q     <= 1'b0;
         alu_control_q <= '0;
         reg_write_q   <= 1'b0;
      end else if (io.flush) begin
         // Zeroed payload makes the bubble an add 0+0 with no register write.
         valid_q       <= 1'b0;
         rd1_q         <= '0;
         rd2_q         <= '0;
         imm_q         <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         alu_src_q     <= 1'b0;
         alu_control_q <= '0;
         reg_write_q   <= 1'b0;
      end else if (accept) begin
         valid_q       <= 1'b1;
         rd1_q         <= io.in_rd1;
         rd2_q         <= io.in_rd2;
         imm_q         <= io.in_imm;
         rs1_q         <= io.in_rs1;
         rs2_q         <= io.in_rs2;
         rd_q          <= io.in_rd;
         alu_src_q     <= io.in_alu_src;
         alu_control_q <= io.in_alu_control;
         reg_write_q   <= io.in_reg_write;
      end else if (valid_q && io.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Forwarding on the held source indices; MEM is younger than WB so it wins, x0 never forwards.
   always_comb begin
      op_a = rd1_q;
      if (io.fwd_mem_en && (io.fwd_mem_rd == rs1_q) && (rs1_q != '0))
         op_a = io.fwd_mem_data;
      else if (io.fwd_wb_en && (io.fwd_wb_rd == rs1_q) && (rs1_q != '0))
         op_a = io.fwd_wb_data;

      op_b = rd2_q;
      if (io.fwd_mem_en && (io.fwd_mem_rd == rs2_q) && (rs2_q != '0))
         op_b = io.fwd_mem_data;
      else if (io.fwd_wb_en && (io.fwd_wb_rd == rs2_q) && (rs2_q != '0))
         op_b = io.fwd_wb_data;
   end

   assign io.out_valid      = valid_q;
   assign io.alu_a          = op_a;
   assign io.alu_b          = alu_src_q ? imm_q : op_b;
   assign io.alu_control    = alu_control_q;
   assign io.out_rd         = rd_q;
   assign io.out_reg_write  = reg_write_q && valid_q;
   assign io.out_store_data = op_b;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized traffic vs. a reference model.
module tb_ex_operand_stage;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        alu_src;
      logic [2:0]  alu_control;
      logic        reg_write;
   } instr_t;

   logic clk;
   logic rst;

   ex_operand_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

   ex_operand_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_fail   = 0;

   // Reference model: the instruction currently presented to the ALU and whether it is live.
   instr_t shown;
   bit     live;

   function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] held);
      if (rs == 5'd0) return held;
      if (bus.fwd_mem_en && bus.fwd_mem_rd == rs) return bus.fwd_mem_data;
      if (bus.fwd_wb_en && bus.fwd_wb_rd == rs) return bus.fwd_wb_data;
      return held;
   endfunction

   // {in_ready, out_valid, alu_a, alu_b, alu_control, out_rd, out_reg_write, out_store_data}
   function automatic logic [106:0] expected();
      logic [31:0] a, s, b;
      a = ref_fwd(shown.rs1, shown.rd1);
      s = ref_fwd(shown.rs2, shown.rd2);
      b = shown.alu_src ? shown.imm : s;
      return {(!live || bus.out_ready), live, a, b, shown.alu_control, shown.rd,
              (shown.reg_write && live), s};
   endfunction

   function automatic logic [106:0] observed();
      return {bus.in_ready, bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control,
              bus.out_rd, bus.out_reg_write, bus.out_store_data};
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i.rd1         = $urandom;
      i.rd2         = $urandom;
      i.imm         = $urandom;
      i.rs1         = 5'($urandom_range(0, 3));
      i.rs2         = 5'($urandom_range(0, 3));
      i.rd          = 5'($urandom);
      i.alu_src     = 1'($urandom);
      i.alu_control = 3'($urandom);
      i.reg_write   = 1'($urandom);
      return i;
   endfunction

   task automatic present(input instr_t i, input logic v);
      bus.in_valid       = v;
      bus.in_rd1         = i.rd1;
      bus.in_rd2         = i.rd2;
      bus.in_imm         = i.imm;
      bus.in_rs1         = i.rs1;
      bus.in_rs2         = i.rs2;
      bus.in_rd          = i.rd;
      bus.in_alu_src     = i.alu_src;
      bus.in_alu_control = i.alu_control;
      bus.in_reg_write   = i.reg_write;
   endtask

   task automatic no_fwd();
      bus.fwd_mem_en   = 1'b0;
      bus.fwd_mem_rd   = '0;
      bus.fwd_mem_data = '0;
      bus.fwd_wb_en    = 1'b0;
      bus.fwd_wb_rd    = '0;
      bus.fwd_wb_data  = '0;
   endtask

   // Advance one clock, applying the stage's handshake rules to the model, then settle 1ns past the edge.
   task automatic tick();
      instr_t cur;
      cur = {bus.in_rd1, bus.in_rd2, bus.in_imm, bus.in_rs1, bus.in_rs2, bus.in_rd,
             bus.in_alu_src, bus.in_alu_control, bus.in_reg_write};
      @(posedge clk);
      if (rst || bus.flush) begin
         live  = 1'b0;
         shown = '0;
      end else if (bus.in_valid && (!live || bus.out_ready)) begin
         live  = 1'b1;
         shown = cur;
      end else if (live && bus.out_ready) begin
         live = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (observed() !== {1'b1, 106'd0}) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=%h", observed(), {1'b1, 106'd0});
      end
      rst = 1'b0;
      #1;
   endtask

   task automatic test_basic();
      instr_t i;
      i = '0;
      i.rd1 = 32'd5; i.rd2 = 32'd3; i.rs1 = 5'd1; i.rs2 = 5'd2; i.rd = 5'd9;
      i.alu_control = 3'b001; i.reg_write = 1'b1;
      bus.out_ready = 1'b1;
      present(i, 1'b1);
      tick();
      present('0, 1'b0);
      #1;
      n_checks++;
      if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control} !== {1'b1, 32'd5, 32'd3, 3'b001}) begin
         n_fail++;
         $display("FAIL basic_load got v=%b a=%h b=%h op=%b exp v=1 a=5 b=3 op=001",
                  bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control);
      end
      n_checks++;
      if (observed() !== expected()) begin
         n_fail++;
         $display("FAIL basic_model got=%h exp=%h", observed(), expected());
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drain got out_valid=%b exp 0", bus.out_valid);
      end
   endtask

   task automatic test_forwarding();
      instr_t i;
      i = '0;
      i.rd1 = 32'h0000_1234; i.rs1 = 5'd7; i.rs2 = 5'd7; i.rd2 = 32'h0000_5678;
      bus.out_ready = 1'b0;
      present(i, 1'b1);
      tick();
      present('0, 1'b0);
      bus.fwd_mem_en = 1'b1; bus.fwd_mem_rd = 5'd7; bus.fwd_mem_data = 32'hAA;
      bus.fwd_wb_en  = 1'b1; bus.fwd_wb_rd  = 5'd7; bus.fwd_wb_data  = 32'hBB;
      #1;
      n_checks++;
      if (bus.alu_a !== 32'hAA || bus.out_store_data !== 32'hAA) begin
         n_fail++;
         $display("FAIL fwd_mem_priority got a=%h sd=%h exp aa", bus.alu_a, bus.out_store_data);
      end
      bus.fwd_mem_en = 1'b0;
      #1;
      n_checks++;
      if (bus.alu_a !== 32'hBB) begin
         n_fail++;
         $display("FAIL fwd_wb got a=%h exp bb", bus.alu_a);
      end
      bus.fwd_wb_en = 1'b0;
      #1;
      n_checks++;
      if (bus.alu_a !== 32'h1234 || bus.out_store_data !== 32'h5678) begin
         n_fail++;
         $display("FAIL fwd_none got a=%h sd=%h exp 1234/5678", bus.alu_a, bus.out_store_data);
      end
      n_checks++;
      if (observed() !== expected()) begin
         n_fail++;
         $display("FAIL fwd_model got=%h exp=%h", observed(), expected());
      end
      bus.out_ready = 1'b1;
      tick();
      no_fwd();
   endtask

   task automatic test_x0_imm();
      instr_t i;
      i = '0;
      i.rd2 = 32'h55; i.rs2 = 5'd0; i.rs1 = 5'd0; i.rd1 = 32'h66;
      bus.out_ready = 1'b1;
      present(i, 1'b1);
      tick();
      present('0, 1'b0);
      bus.fwd_mem_en = 1'b1; bus.fwd_mem_rd = 5'd0; bus.fwd_mem_data = 32'hFFFF_FFFF;
      bus.fwd_wb_en  = 1'b1; bus.fwd_wb_rd  = 5'd0; bus.fwd_wb_data  = 32'hFFFF_FFFF;
      #1;
      n_checks++;
      if (bus.alu_b !== 32'h55 || bus.out_store_data !== 32'h55 || bus.alu_a !== 32'h66) begin
         n_fail++;
         $display("FAIL x0_no_fwd got a=%h b=%h sd=%h exp 66/55/55",
                  bus.alu_a, bus.alu_b, bus.out_store_data);
      end
      i.alu_src = 1'b1; i.imm = 32'hFFFF_FFFC;
      present(i, 1'b1);
      tick();
      present('0, 1'b0);
      #1;
      n_checks++;
      if (bus.alu_b !== 32'hFFFF_FFFC || bus.out_store_data !== 32'h55) begin
         n_fail++;
         $display("FAIL imm_select got b=%h sd=%h exp fffffffc/55", bus.alu_b, bus.out_store_data);
      end
      tick();
      no_fwd();
   endtask

   task automatic test_stall();
      instr_t a, b;
      logic [106:0] held;
      a = rand_instr(); a.rd = 5'd21;
      b = rand_instr(); b.rd = 5'd22;
      bus.out_ready = 1'b0;
      present(a, 1'b1);
      tick();
      held = observed();
      present(b, 1'b1);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b0 || observed() !== held || observed() !== expected()) begin
            n_fail++;
            $display("FAIL stall_hold cycle=%0d got=%h exp=%h", c, observed(), expected());
         end
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_rd !== 5'd21) begin
         n_fail++;
         $display("FAIL stall_release got rdy=%b rd=%0d exp 1/21", bus.in_ready, bus.out_rd);
      end
      tick();
      present('0, 1'b0);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd22 || observed() !== expected()) begin
         n_fail++;
         $display("FAIL stall_next got v=%b rd=%0d exp 1/22", bus.out_valid, bus.out_rd);
      end
      tick();
   endtask

   task automatic test_flush();
      instr_t a, c;
      a = rand_instr(); a.reg_write = 1'b1;
      c = rand_instr(); c.rd = 5'd30;
      bus.out_ready = 1'b0;
      present(a, 1'b1);
      tick();
      bus.flush = 1'b1;
      present(c, 1'b1);
      tick();
      bus.flush = 1'b0;
      present('0, 1'b0);
      #1;
      n_checks++;
      if ({bus.out_valid, bus.out_reg_write, bus.alu_a, bus.alu_b, bus.alu_control} !== 69'd0) begin
         n_fail++;
         $display("FAIL flush_bubble got v=%b we=%b a=%h b=%h op=%b exp all 0",
                  bus.out_valid, bus.out_reg_write, bus.alu_a, bus.alu_b, bus.alu_control);
      end
      bus.out_ready = 1'b1;
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_rd === 5'd30) begin
         n_fail++;
         $display("FAIL flush_dropped got v=%b rd=%0d exp v=0", bus.out_valid, bus.out_rd);
      end
   endtask

   task automatic test_back_to_back();
      instr_t i;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         i = rand_instr();
         i.rd = 5'(11 + k);
         present(i, 1'b1);
         tick();
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'(11 + k)) begin
            n_fail++;
            $display("FAIL b2b_order k=%0d got v=%b rd=%0d exp v=1 rd=%0d",
                     k, bus.out_valid, bus.out_rd, 11 + k);
         end
      end
      present('0, 1'b0);
      bus.out_ready = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      live  = 1'b0;
      shown = '0;
      n_checks++;
      if (observed() !== {1'b1, 106'd0}) begin
         n_fail++;
         $display("FAIL async_reset got=%h exp=%h", observed(), {1'b1, 106'd0});
      end
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      #1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         present(rand_instr(), 1'($urandom_range(0, 3) != 0));
         bus.out_ready    = 1'($urandom_range(0, 3) != 0);
         bus.flush        = ($urandom_range(0, 15) == 0);
         bus.fwd_mem_en   = 1'($urandom);
         bus.fwd_mem_rd   = 5'($urandom_range(0, 3));
         bus.fwd_mem_data = $urandom;
         bus.fwd_wb_en    = 1'($urandom);
         bus.fwd_wb_rd    = 5'($urandom_range(0, 3));
         bus.fwd_wb_data  = $urandom;
         #1;
         n_checks++;
         if (observed() !== expected()) begin
            n_fail++;
            $display("FAIL random cycle=%0d got=%h exp=%h", c, observed(), expected());
         end
         tick();
      end
      bus.flush = 1'b0;
      present('0, 1'b0);
      no_fwd();
   endtask

   initial begin
      rst   = 1'b1;
      live  = 1'b0;
      shown = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      present('0, 1'b0);
      no_fwd();
      test_reset();
      test_basic();
      test_forwarding();
      test_x0_imm();
      test_stall();
      test_flush();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
